// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the boot ROM loader.
// The optional checksum path is enabled by defining ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  // Bytes packed into one ROM word.
  function automatic int bpw(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/rom_loader_packer.sv
// Little-endian byte packer: shifts bytes in from the top so the first byte of a
// word ends up in bits [7:0]; word_o already includes the byte being shifted.
module rom_loader_packer
  import rom_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_full_o
);

  localparam int BPW = bpw(DATA_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] word_r;
  logic [CW-1:0]         cnt_r;

  generate
    if (BPW > 1) begin : g_multi
      assign word_o = {byte_i, word_r[DATA_WIDTH-1:BYTE_W]};
    end else begin : g_single
      assign word_o = byte_i;
    end
  endgenerate

  assign word_full_o = shift_i && (cnt_r == CW'(BPW - 1));

  // Assembly register and byte-in-word counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_r <= {DATA_WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (clear_i) begin
      word_r <= {DATA_WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (shift_i) begin
      word_r <= word_o;
      cnt_r  <= word_full_o ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      word_r <= word_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot ROM writer: packs a valid/ready byte stream into words and writes them from address 0.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing checksum byte and report err_o.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int WORDS      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int WCW = $clog2(WORDS + 1);

  generate
    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH < BYTE_W) begin : g_dw_bad
      $error("rom_loader: DATA_WIDTH must be a nonzero multiple of 8");
    end
    if (WORDS < 1 || WORDS > (2 ** ADDR_WIDTH)) begin : g_words_bad
      $error("rom_loader: WORDS must lie in 1..2**ADDR_WIDTH");
    end
  endgenerate

  loader_state_e         state_r, state_s;
  logic                  byte_ready_s, xfer_s, shift_s, clear_s, last_word_s;
  logic                  word_full_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [ADDR_WIDTH-1:0] addr_r, wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [WCW-1:0]        word_cnt_r;
  logic                  wr_en_r, busy_r, done_r;

  assign byte_ready_s = (state_r == LOAD) || (state_r == CHECK);
  assign xfer_s       = byte_valid_i && byte_ready_s;
  assign shift_s      = xfer_s && (state_r == LOAD);
  assign last_word_s  = (word_cnt_r == WCW'(WORDS - 1));

  rom_loader_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_s),
    .shift_i     (shift_s),
    .byte_i      (byte_i),
    .word_o      (word_s),
    .word_full_o (word_full_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start_i only counts in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    clear_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_s = LOAD;
          clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        if (shift_s && word_full_s) begin
          state_s = WRITE;
        end else begin
          state_s = LOAD;
        end
      end
      WRITE: begin
        if (last_word_s) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_s = CHECK;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = LOAD;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer_s) begin
          state_s = DONE;
        end else begin
          state_s = CHECK;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Address/word counters, write port registers and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      word_cnt_r <= {WCW{1'b0}};
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (clear_s) begin
        addr_r     <= {ADDR_WIDTH{1'b0}};
        word_cnt_r <= {WCW{1'b0}};
      end else if (state_r == WRITE) begin
        addr_r     <= addr_r + ADDR_WIDTH'(1);
        word_cnt_r <= word_cnt_r + WCW'(1);
      end
      if (shift_s && word_full_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= word_s;
      end
      wr_en_r <= (state_s == WRITE);
      busy_r  <= (state_s == LOAD) || (state_s == WRITE) || (state_s == CHECK);
      done_r  <= (state_s == DONE);
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] acc_r;
  logic [7:0] acc_sum_s;
  logic       err_r;

  assign acc_sum_s = acc_r + byte_i;

  // Running mod-256 sum; the checksum byte must bring it to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r <= 8'h00;
      err_r <= 1'b0;
    end else if (clear_s) begin
      acc_r <= 8'h00;
      err_r <= 1'b0;
    end else if (xfer_s) begin
      acc_r <= acc_sum_s;
      if (state_r == CHECK) begin
        err_r <= (acc_sum_s != 8'h00);
      end
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign byte_ready_o = byte_ready_s;
  assign wr_en_o      = wr_en_r;
  assign wr_addr_o    = wr_addr_r;
  assign wr_data_o    = wr_data_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a reference model derives the expected ROM writes
// from the byte stream; a negedge monitor pops and compares every wr_en_o pulse.
module tb_rom_loader;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int WORDS = 5;
  localparam int BPW   = DW / 8;
  localparam int NB    = WORDS * BPW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_d = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready_o, wr_en_o, busy_o, done_o, err_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  wr_t sb_q[$];
  int  wr_cyc_q[$];

  rom_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS(WORDS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .byte_i       (byte_d),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard and block the stream.
  always @(negedge clk) begin
    if (rst_ni && wr_en_o) begin
      wr_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", wr_addr_o, wr_data_o);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", 32'(wr_data_o), 32'(e.data));
      end
      chk("ready_in_write", 32'(byte_ready_o), 32'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte after an optional random gap; returns just after it transfers.
  task automatic push_byte(input logic [7:0] b, input int maxgap);
    int gaps;
    int n;
    gaps = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    if (gaps > 0) begin
      byte_valid = 1'b0;
      repeat (gaps) begin
        @(posedge clk); #1;
      end
    end
    byte_d = b;
    byte_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      chk("byte_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  task automatic run_session(input logic [7:0] d [NB], input int maxgap, input logic [7:0] cks,
                             input bit mid_start, input bit end_start, input bit pre_pending);
    int  sum;
    bit  exp_err;
    wr_t e;
    sum = 0;
    for (int w = 0; w < WORDS; w++) begin
      e.addr = AW'(w);
      e.data = '0;
      for (int k = 0; k < BPW; k++) e.data = e.data | (DW'(d[w*BPW+k]) << (8*k));
      sb_q.push_back(e);
    end
    for (int i = 0; i < NB; i++) sum += int'(d[i]);
`ifdef ROM_LOADER_CHECKSUM_EN
    exp_err = (((sum + int'(cks)) % 256) != 0);
`else
    exp_err = 1'b0;
`endif
    if (pre_pending) begin
      byte_d = d[0];
      byte_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("pending_not_taken", 32'(byte_ready_o), 32'd0);
      end
      @(posedge clk); #1;
    end
    pulse_start();
    chk("start_clears_done", 32'(done_o), 32'd0);
    chk("start_sets_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < NB; i++) begin
      push_byte(d[i], maxgap);
      if (mid_start && i == 2) begin
        byte_valid = 1'b0;
        pulse_start();
      end
    end
    if (end_start) begin
      byte_valid = 1'b0;
      pulse_start();
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    push_byte(cks, maxgap);
`endif
    byte_valid = 1'b0;
    wait_done();
    chk("busy_after_done", 32'(busy_o), 32'd0);
    chk("err", 32'(err_o), 32'(exp_err));
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done_o), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  logic [7:0] data [NB];
  logic [7:0] cks;
  int         s;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_addr", 32'(wr_addr_o), 32'd0);
    chk("rst_data", 32'(wr_data_o), 32'd0);
    chk("rst_busy_done_err", {29'd0, busy_o, done_o, err_o}, 32'd0);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic load, continuous valid, good checksum; writes BPW+1 cycles apart.
    for (int i = 0; i < NB; i++) data[i] = 8'(i + 1);
    wr_cyc_q.delete();
    run_session(data, 0, 8'hC9, 1'b0, 1'b0, 1'b0);
    chk("write_count", 32'(wr_cyc_q.size()), 32'(WORDS));
    for (int i = 1; i < wr_cyc_q.size(); i++)
      chk("write_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'(BPW + 1));

    // Stalls, mid-session start, bad checksum.
    run_session(data, 3, 8'hC8, 1'b1, 1'b0, 1'b0);

    // Bytes pending in DONE, start coincident with final write.
    for (int i = 0; i < NB; i++) data[i] = 8'($urandom);
    s = 0;
    for (int i = 0; i < NB; i++) s += int'(data[i]);
    cks = 8'(256 - (s % 256));
    run_session(data, 2, cks, 1'b0, 1'b1, 1'b1);

    // Reset after three bytes: only word 0 has been written.
    pulse_start();
    begin
      wr_t e;
      e.addr = '0;
      e.data = {8'h22, 8'h11};
      sb_q.push_back(e);
    end
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    push_byte(8'h33, 0);
    rst_ni = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en_o), 32'd0);
    chk("midrst_addr", 32'(wr_addr_o), 32'd0);
    chk("midrst_data", 32'(wr_data_o), 32'd0);
    chk("midrst_busy_done_err", {29'd0, busy_o, done_o, err_o}, 32'd0);
    chk("midrst_ready", 32'(byte_ready_o), 32'd0);
    chk("midrst_sb", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Random sessions: new session restarts at address 0.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) data[i] = 8'($urandom);
      s = 0;
      for (int i = 0; i < NB; i++) s += int'(data[i]);
      cks = 8'(256 - (s % 256) + int'($urandom_range(0, 1)));
      run_session(data, 4, cks, r[0], 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("final_sb", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
